// File: rtl/gpio_serial_loader_if.sv
// Handshake and serial-stream signals for the GPIO configuration loader.
// The master side is the loader and the slave side is the register file plus the pad chain.
interface gpio_serial_loader_if #(
    parameter int NPADS    = 38,
    parameter int CFG_BITS = 10
);
    localparam int AW = $clog2(NPADS);

    logic                start;
    logic [AW-1:0]       cfg_addr;
    logic [CFG_BITS-1:0] cfg_data;
    logic                busy;
    logic                done;
    logic                serial_clock;
    logic                serial_data;
    logic                serial_load;

    modport master (
        input  start, cfg_data,
        output cfg_addr, busy, done,
        output serial_clock, serial_data, serial_load
    );

    modport slave (
        output start, cfg_data,
        input  cfg_addr, busy, done,
        input  serial_clock, serial_data, serial_load
    );
endinterface

// File: rtl/gpio_serial_loader.sv
// Serial configuration master for the user-project GPIO pad chain.
// It fetches one word per pad, shifts each word out MSB first, then strobes serial_load.
module gpio_serial_loader #(
    parameter int NPADS    = 38,
    parameter int CFG_BITS = 10,
    parameter int CLK_DIV  = 2
) (
    input logic                  clock,
    input logic                  reset,
    gpio_serial_loader_if.master bus
);
    localparam int AW = $clog2(NPADS);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(CFG_BITS);

    localparam logic [AW-1:0] ADDR_LAST = AW'(NPADS - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOW,
        S_HIGH,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DW-1:0]       r_div;
    logic [BW-1:0]       r_bit;
    logic [AW-1:0]       r_addr;
    logic [CFG_BITS-1:0] r_word;
    logic                r_busy;
    logic                r_done;
    logic                r_sclk;
    logic                r_sdata;
    logic                r_load;

    logic w_div_end;
    logic w_bit_end;
    logic w_addr_end;
    logic w_stay;

    assign w_div_end  = (r_div == DIV_LAST);
    assign w_bit_end  = (r_bit == '0);
    assign w_addr_end = (r_addr == ADDR_LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_FETCH;
            S_FETCH: w_next = S_LOW;
            S_LOW:   if (w_div_end) w_next = S_HIGH;
            S_HIGH: begin
                if (w_div_end) begin
                    if (!w_bit_end)       w_next = S_LOW;
                    else if (!w_addr_end) w_next = S_FETCH;
                    else                  w_next = S_LOAD;
                end
            end
            S_LOAD:  if (w_div_end) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The divider restarts on every state entry and only runs in timed phases.
    assign w_stay = (w_next == r_state) &&
                    (r_state inside {S_LOW, S_HIGH, S_LOAD});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_addr  <= '0;
            r_word  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_div   <= w_stay ? r_div + DW'(1) : '0;
            r_busy  <= !(w_next inside {S_IDLE, S_DONE});
            r_done  <= (w_next == S_DONE);
            r_sclk  <= (w_next == S_HIGH);
            r_load  <= (w_next == S_LOAD);

            // Data is launched on LOW entry so it leads the rising edge by CLK_DIV.
            if (r_state == S_FETCH) begin
                r_word  <= bus.cfg_data;
                r_bit   <= BIT_LAST;
                r_sdata <= bus.cfg_data[CFG_BITS-1];
            end else if (r_state == S_HIGH && w_next == S_LOW) begin
                r_word  <= r_word << 1;
                r_bit   <= r_bit - BW'(1);
                r_sdata <= r_word[CFG_BITS-2];
            end

            if (r_state == S_HIGH && w_next == S_FETCH) begin
                r_addr <= r_addr + AW'(1);
            end else if (w_next == S_DONE) begin
                r_addr <= '0;
            end
        end
    end

    assign bus.cfg_addr     = r_addr;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.serial_clock = r_sclk;
    assign bus.serial_data  = r_sdata;
    assign bus.serial_load  = r_load;
endmodule
